// File: rtl/rgb2gray_pkg.sv
// rgb2gray_pkg: frame geometry, word widths, luma weights and FSM states
// shared by the RGB444-to-grayscale frame engine.
package rgb2gray_pkg;

  localparam int IMG_W   = 320;
  localparam int IMG_H   = 240;
  localparam int NPIX    = IMG_W * IMG_H;
  localparam int ADDR_W  = 17;
  localparam int COLOR_W = 12;
  localparam int GRAY_W  = 8;

  localparam logic [15:0] LUMA_R = 16'd77;
  localparam logic [15:0] LUMA_G = 16'd150;
  localparam logic [15:0] LUMA_B = 16'd29;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  // x*17 is the 4-bit nibble repeated into a byte
  function automatic logic [15:0] expand4(input logic [3:0] x);
    return {8'h00, x, x};
  endfunction

endpackage

// File: rtl/rgb444_to_gray.sv
// rgb444_to_gray: combinational RGB444 -> 8-bit luma.
// Each nibble is widened to 8 bits, weighted 77/150/29, then >> 8.
import rgb2gray_pkg::*;

module rgb444_to_gray (
  input  logic [COLOR_W-1:0] color_i,
  output logic [GRAY_W-1:0]  gray_o
);

  logic [15:0] acc;

  // weighted sum peaks at 256*255, so 16 bits never overflow
  always_comb begin
    acc = LUMA_R * expand4(color_i[11:8])
        + LUMA_G * expand4(color_i[7:4])
        + LUMA_B * expand4(color_i[3:0]);
  end

  assign gray_o = acc[15:8];

endmodule

// File: rtl/top_rgb2gray.sv
// top_rgb2gray: color BRAM -> luma pipeline -> gray BRAM frame engine.
// Define COLOR_READBACK_EN to enable host readback of the color BRAM.
import rgb2gray_pkg::*;

module top_rgb2gray #(
  parameter int FRAME_W = rgb2gray_pkg::IMG_W,
  parameter int FRAME_H = rgb2gray_pkg::IMG_H
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic [COLOR_W-1:0] AXI_WRDATA_COLOR_BRAM,
  input  logic               AXI_WRREQUEST_COLOR_BRAM,
  input  logic [ADDR_W-1:0]  AXI_ADDRESS_CTRL_COLOR,
  input  logic               AXI_RD_REQUEST,
  output logic [COLOR_W-1:0] AXI_RD_DATA,
  output logic               DONE_WRITE_COLOR_BRAM,
  input  logic               STATE_SELECT,
  input  logic               AXI_START_PROCESSING,
  output logic [GRAY_W-1:0]  DATA_FR_GRAY_BRAM,
  input  logic [ADDR_W-1:0]  AXI_ADDRESS_CTRL_GRAY,
  input  logic               AXI_RDREQUEST_GRAY_BRAM,
  output logic               DONE_WRITE_GRAY_BRAM
);

  localparam int NPIX_L = FRAME_W * FRAME_H;
  localparam int AW_L   = (NPIX_L > 1) ? $clog2(NPIX_L) : 1;
  localparam logic [ADDR_W-1:0] LIM  = ADDR_W'(NPIX_L);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX_L - 1);

  logic [COLOR_W-1:0] color_mem [NPIX_L];
  logic [GRAY_W-1:0]  gray_mem  [NPIX_L];

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic               v1_q, v1_d;
  logic               v2_q;
  logic [AW_L-1:0]    addr1_q, addr2_q;
  logic [COLOR_W-1:0] color_rd_q;
  logic [GRAY_W-1:0]  gray_c, gray_q;
  logic               gdone_q, gdone_d;
  logic               armed_q, armed_d;
  logic               cdone_q, cdone_d;
  logic [GRAY_W-1:0]  gray_rd_q;
  logic               wr_ok;

  assign wr_ok = STATE_SELECT && AXI_WRREQUEST_COLOR_BRAM
              && (AXI_ADDRESS_CTRL_COLOR < LIM);

  // host port: color BRAM write
  always_ff @(posedge i_CLK) begin
    if (wr_ok)
      color_mem[AXI_ADDRESS_CTRL_COLOR[AW_L-1:0]] <= AXI_WRDATA_COLOR_BRAM;
  end

  // engine port: color BRAM read at the scan address
  always_ff @(posedge i_CLK) begin
    color_rd_q <= color_mem[rd_addr_q[AW_L-1:0]];
  end

  // load tracking: arm on pixel 0, fire once on the last pixel
  always_comb begin
    armed_d = armed_q;
    cdone_d = 1'b0;
    if (wr_ok && AXI_ADDRESS_CTRL_COLOR == '0) begin
      armed_d = 1'b1;
    end else if (wr_ok && AXI_ADDRESS_CTRL_COLOR == LAST && armed_q) begin
      armed_d = 1'b0;
      cdone_d = 1'b1;
    end
  end

  // load tracking registers
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      armed_q <= 1'b0;
      cdone_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
      cdone_q <= cdone_d;
    end
  end

  rgb444_to_gray u_conv (
    .color_i (color_rd_q),
    .gray_o  (gray_c)
  );

  // scan FSM: host ownership aborts, flush ends on the last gray write
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    gdone_d   = 1'b0;
    v1_d      = (state_q == RUN) && !STATE_SELECT;
    unique case (state_q)
      IDLE: begin
        if (AXI_START_PROCESSING && !STATE_SELECT) begin
          state_d   = RUN;
          rd_addr_d = '0;
        end
      end
      RUN: begin
        if (STATE_SELECT)
          state_d = IDLE;
        else if (rd_addr_q == LAST)
          state_d = FLUSH;
        else
          rd_addr_d = rd_addr_q + ADDR_W'(1);
      end
      FLUSH: begin
        if (STATE_SELECT) begin
          state_d = IDLE;
        end else if (v2_q && !v1_q) begin
          state_d = IDLE;
          gdone_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and read/convert pipeline registers
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      addr1_q   <= '0;
      addr2_q   <= '0;
      gray_q    <= '0;
      gdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      v1_q      <= v1_d;
      v2_q      <= v1_q && !STATE_SELECT;
      addr1_q   <= rd_addr_q[AW_L-1:0];
      addr2_q   <= addr1_q;
      gray_q    <= gray_c;
      gdone_q   <= gdone_d;
    end
  end

  // engine port: gray BRAM write
  always_ff @(posedge i_CLK) begin
    if (v2_q)
      gray_mem[addr2_q] <= gray_q;
  end

  // host port: gray BRAM read, holds between strobes
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST)
      gray_rd_q <= '0;
    else if (STATE_SELECT && AXI_RDREQUEST_GRAY_BRAM)
      gray_rd_q <= (AXI_ADDRESS_CTRL_GRAY < LIM)
                 ? gray_mem[AXI_ADDRESS_CTRL_GRAY[AW_L-1:0]] : '0;
  end

`ifdef COLOR_READBACK_EN
  logic [COLOR_W-1:0] rd_data_q;

  // host port: color BRAM readback, holds between strobes
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST)
      rd_data_q <= '0;
    else if (STATE_SELECT && AXI_RD_REQUEST)
      rd_data_q <= (AXI_ADDRESS_CTRL_COLOR < LIM)
                 ? color_mem[AXI_ADDRESS_CTRL_COLOR[AW_L-1:0]] : '0;
  end

  assign AXI_RD_DATA = rd_data_q;
`else
  logic rd_req_unused;
  assign rd_req_unused = AXI_RD_REQUEST;
  assign AXI_RD_DATA   = '0;
`endif

  assign DONE_WRITE_COLOR_BRAM = cdone_q;
  assign DONE_WRITE_GRAY_BRAM  = gdone_q;
  assign DATA_FR_GRAY_BRAM     = gray_rd_q;

endmodule

// File: tb/tb_top_rgb2gray.sv
// tb_top_rgb2gray: scoreboard bench for top_rgb2gray on a 16x8 frame.
// Honours COLOR_READBACK_EN to pick the color readback expectation.
module tb_top_rgb2gray;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int NP = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] wdata = '0;
  logic        wreq = 1'b0;
  logic [16:0] caddr = '0;
  logic        crd = 1'b0;
  logic [11:0] rdata;
  logic        cdone;
  logic        sel = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  gdata;
  logic [16:0] gaddr = '0;
  logic        grd = 1'b0;
  logic        gdone;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q [$];

  top_rgb2gray #(.FRAME_W(W), .FRAME_H(H)) dut (
    .i_CLK                    (clk),
    .i_RST                    (rst),
    .AXI_WRDATA_COLOR_BRAM    (wdata),
    .AXI_WRREQUEST_COLOR_BRAM (wreq),
    .AXI_ADDRESS_CTRL_COLOR   (caddr),
    .AXI_RD_REQUEST           (crd),
    .AXI_RD_DATA              (rdata),
    .DONE_WRITE_COLOR_BRAM    (cdone),
    .STATE_SELECT             (sel),
    .AXI_START_PROCESSING     (start),
    .DATA_FR_GRAY_BRAM        (gdata),
    .AXI_ADDRESS_CTRL_GRAY    (gaddr),
    .AXI_RDREQUEST_GRAY_BRAM  (grd),
    .DONE_WRITE_GRAY_BRAM     (gdone)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int i);
    return (12'h111 + 8 * i) % 4096;
  endfunction

  function automatic int gray_ref(input int c);
    int r, g, b;
    r = ((c >> 8) & 15) * 17;
    g = ((c >> 4) & 15) * 17;
    b = (c & 15) * 17;
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_count(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (gdone) pulses++;
    end
  endtask

  task automatic run_frame(output int lat);
    sel   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!gdone && lat < NP + 50) begin
      tick();
      lat++;
    end
    if (!gdone) lat = -1;
  endtask

  initial begin
    int p, lat, e;

    repeat (3) tick();
    check("rst_cdone", cdone, 0);
    check("rst_gdone", gdone, 0);
    check("rst_gdata", gdata, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b0;
    tick();

    sel  = 1'b1;
    wreq = 1'b1;
    for (int i = 0; i < NP; i++) begin
      caddr = 17'(i);
      wdata = 12'(pix(i));
      tick();
      check("load_done", cdone, (i == NP - 1) ? 1 : 0);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      check("load_repeat", cdone, 0);
    end

    caddr = 17'(NP);
    wdata = 12'hABC;
    tick();
    sel   = 1'b0;
    caddr = 17'd3;
    tick();
    wreq  = 1'b0;
    check("drop_cdone", cdone, 0);

    sel   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    idle_count(NP + 10, p);
    check("start_sel1", p, 0);

    sel   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (NP / 2) tick();
    rst = 1'b1;
    tick();
    check("midrst_gdone", gdone, 0);
    check("midrst_gdata", gdata, 0);
    check("midrst_cdone", cdone, 0);
    rst = 1'b0;
    idle_count(NP + 10, p);
    check("midrst_idle", p, 0);

    run_frame(lat);
    check("run_latency", lat, NP + 3);
    tick();
    check("run_single", gdone, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    sel = 1'b1;
    idle_count(NP + 10, p);
    check("abort_nodone", p, 0);

    run_frame(lat);
    check("rerun_latency", lat, NP + 3);
    tick();

    sel = 1'b1;
    grd = 1'b1;
    gaddr = 17'(NP);
    exp_q.push_back(0);
    tick();
    check("gray_oob", gdata, exp_q.pop_front());
    for (int a = 0; a < NP; a++) begin
      gaddr = 17'(a);
      exp_q.push_back(gray_ref(pix(a)));
      tick();
      check("gray_rd", gdata, exp_q.pop_front());
    end
    grd   = 1'b0;
    gaddr = 17'd7;
    repeat (2) tick();
    check("gray_hold", gdata, gray_ref(pix(NP - 1)));
    check("gray_ref_111", gray_ref(pix(0)), 17);

    crd = 1'b1;
    for (int k = 0; k < 3; k++) begin
      caddr = (k == 0) ? 17'd5 : (k == 1) ? 17'd3 : 17'(NP);
`ifdef COLOR_READBACK_EN
      e = (k == 0) ? 12'h139 : (k == 1) ? pix(3) : 0;
`else
      e = 0;
`endif
      exp_q.push_back(e);
      tick();
      check("color_rd", rdata, exp_q.pop_front());
    end
    crd = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
